// File: rtl/mode2_sub_pipe_pkg.sv
// Shared definitions for the softmax mode-2 subtract stage.
// Element format comes from the datapath-wide macros (defaulted to fp16
// when the surrounding build does not supply them). Also provides the
// lane-slice macro, pipeline depth bounds and the status bit layout
// produced by each lane subtractor.

`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef MANTISSA
`define MANTISSA 10
`endif
`ifndef EXPONENT
`define EXPONENT 5
`endif
`ifndef IEEE_COMPLIANCE
`define IEEE_COMPLIANCE 1
`endif

// Lane idx of a packed multi-lane vector.
`define M2_LANE(vec, idx) vec[(idx)*mode2_sub_pipe_pkg::DW +: mode2_sub_pipe_pkg::DW]

package mode2_sub_pipe_pkg;

    localparam int DW        = `DATAWIDTH;
    localparam int MANT_W    = `MANTISSA;
    localparam int EXP_W     = `EXPONENT;
    localparam int IEEE_COMP = `IEEE_COMPLIANCE;

    localparam int PIPE_MIN  = 1;
    localparam int PIPE_MAX  = 4;
    localparam int STATUS_W  = 8;

    // Status bit positions (subtractor status word layout).
    localparam int ST_ZERO    = 0;
    localparam int ST_INF     = 1;
    localparam int ST_INVALID = 2;
    localparam int ST_TINY    = 3;
    localparam int ST_HUGE    = 4;
    localparam int ST_INEXACT = 5;

    typedef logic [STATUS_W-1:0] status_t;

endpackage

// File: rtl/mode2_sub_lane.sv
// One lane of the subtract stage: z = a - b in the package floating-point
// format, round-to-nearest-even, plus an 8-bit exception status word.
// Ports: a, b (operands), z (difference), status (zero/inf/invalid/tiny/
// huge/inexact flags). Purely combinational; the caller registers z.
// Subnormals are honoured when IEEE compliance is on, flushed otherwise.

module mode2_sub_lane
    import mode2_sub_pipe_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] z,
    output status_t       status
);

    localparam int MW     = MANT_W + 1;   // significand incl. hidden bit
    localparam int XW     = MW + 3;       // plus guard, round, sticky
    localparam int SW     = XW + 1;       // plus carry
    localparam int EMAX_I = (1 << EXP_W) - 1;
    localparam logic [EXP_W-1:0]  EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]  EXP_ZERO  = {EXP_W{1'b0}};
    localparam logic [MANT_W-1:0] MANT_ZERO = {MANT_W{1'b0}};

    logic                sa, sb, sx, sy, eff_sub, swap;
    logic                a_nan, b_nan, a_inf, b_inf;
    logic [EXP_W-1:0]    ea, eb, ex, ey;
    logic [MANT_W-1:0]   fa, fb, fx, fy, frac;
    logic [XW-1:0]       mx, my, aligned, norm;
    logic [2*XW-1:0]     shifted;
    logic [SW-1:0]       sum;
    logic [MW:0]         rounded;
    logic                round_up, inexact;
    int                  d, exeff, eyeff, e_work, e_out;

    // Unpack, align, add/subtract magnitudes, normalise, round, then
    // override with the IEEE special-value results.
    always_comb begin
        sa = a[DW-1];
        sb = ~b[DW-1];                    // subtraction = addition of -b
        ea = a[DW-2 -: EXP_W];
        eb = b[DW-2 -: EXP_W];
        fa = (IEEE_COMP == 0 && ea == EXP_ZERO) ? MANT_ZERO : a[MANT_W-1:0];
        fb = (IEEE_COMP == 0 && eb == EXP_ZERO) ? MANT_ZERO : b[MANT_W-1:0];
        a_nan = (ea == EXP_ONES) && (fa != MANT_ZERO);
        b_nan = (eb == EXP_ONES) && (fb != MANT_ZERO);
        a_inf = (ea == EXP_ONES) && (fa == MANT_ZERO);
        b_inf = (eb == EXP_ONES) && (fb == MANT_ZERO);

        // Larger magnitude goes to x so the magnitude difference is never negative.
        swap = {eb, fb} > {ea, fa};
        sx = swap ? sb : sa;
        sy = swap ? sa : sb;
        ex = swap ? eb : ea;
        ey = swap ? ea : eb;
        fx = swap ? fb : fa;
        fy = swap ? fa : fb;
        eff_sub = sx ^ sy;

        mx = {(ex != EXP_ZERO), fx, 3'b000};
        my = {(ey != EXP_ZERO), fy, 3'b000};
        exeff = (ex == EXP_ZERO) ? 1 : int'(ex);
        eyeff = (ey == EXP_ZERO) ? 1 : int'(ey);
        d = exeff - eyeff;

        // Right-align the smaller operand; shifted-out bits fold into sticky.
        shifted = {my, {XW{1'b0}}} >> d;
        if (d >= XW) begin
            aligned = {{(XW-1){1'b0}}, |my};
        end else begin
            aligned = shifted[2*XW-1:XW] | {{(XW-1){1'b0}}, |shifted[XW-1:0]};
        end

        if (eff_sub) begin
            sum = {1'b0, mx} - {1'b0, aligned};
        end else begin
            sum = {1'b0, mx} + {1'b0, aligned};
        end

        e_work = exeff;
        if (sum[SW-1]) begin
            norm   = {sum[SW-1:2], sum[1] | sum[0]};
            e_work = e_work + 1;
        end else begin
            norm = sum[XW-1:0];
        end
        // Left-normalise after cancellation, stopping at the subnormal floor.
        for (int i = 0; i < XW; i++) begin
            if (!norm[XW-1] && e_work > 1) begin
                norm   = norm << 1;
                e_work = e_work - 1;
            end else begin
                norm = norm;
            end
        end

        inexact  = norm[2] | norm[1] | norm[0];
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded  = {1'b0, norm[XW-1:3]} + {{MW{1'b0}}, round_up};

        if (rounded[MW]) begin
            e_out = e_work + 1;
            frac  = MANT_ZERO;
        end else if (rounded[MW-1]) begin
            e_out = e_work;
            frac  = rounded[MANT_W-1:0];
        end else begin
            e_out = 0;
            frac  = (IEEE_COMP == 0) ? MANT_ZERO : rounded[MANT_W-1:0];
        end

        status = {STATUS_W{1'b0}};
        if (e_out >= EMAX_I) begin
            z = {sx, EXP_ONES, MANT_ZERO};
            status[ST_INF]     = 1'b1;
            status[ST_HUGE]    = 1'b1;
            status[ST_INEXACT] = 1'b1;
        end else if (e_out == 0 && frac == MANT_ZERO) begin
            // Exact cancellation gives +0; only -0 + -0 keeps the sign.
            z = {(eff_sub ? 1'b0 : sx), EXP_ZERO, MANT_ZERO};
            status[ST_ZERO]    = 1'b1;
            status[ST_TINY]    = inexact;
            status[ST_INEXACT] = inexact;
        end else begin
            z = {sx, EXP_W'(e_out), frac};
            status[ST_TINY]    = (e_out == 0);
            status[ST_INEXACT] = inexact;
        end

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            z      = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};
            status = {STATUS_W{1'b0}};
            status[ST_INVALID] = 1'b1;
        end else if (a_inf || b_inf) begin
            z      = {(a_inf ? sa : sb), EXP_ONES, MANT_ZERO};
            status = {STATUS_W{1'b0}};
            status[ST_INF] = 1'b1;
        end else begin
            z      = z;
            status = status;
        end
    end

endmodule

// File: rtl/mode2_sub_pipe.sv
// Pipelined softmax mode-2 stage: out lane i = in lane i - max_reg.
// Ports: clk/reset_n; max_load/max_in load the max register; in_valid/
// in_ready/in_data/in_last form the upstream beat interface; out_valid/
// out_ready/out_data/out_last the downstream one; beat_count counts beats
// of the current vector; status_sticky ORs lane exception status since the
// last max_load; busy flags any beat in flight.
// Subtraction happens at entry, so in-flight beats never see a new max.

module mode2_sub_pipe
    import mode2_sub_pipe_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    max_load,
    input  logic [DW-1:0]           max_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_LANES*DW-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_LANES*DW-1:0] out_data,
    output logic                    out_last,
    output logic [CNT_W-1:0]        beat_count,
    output logic [STATUS_W-1:0]     status_sticky,
    output logic                    busy
);

    localparam int STAGES = (PIPE_STAGES < PIPE_MIN) ? PIPE_MIN :
                            (PIPE_STAGES > PIPE_MAX) ? PIPE_MAX : PIPE_STAGES;
    localparam int LW = NUM_LANES * DW;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              accept_s;
    logic [LW-1:0]     sub_data_s;
    status_t           lane_status_s [NUM_LANES];
    status_t           beat_status_s;
    logic [STAGES-1:0] adv_s;
    logic [STAGES-1:0] vld_r;
    logic [STAGES-1:0] last_r;
    logic [LW-1:0]     data_r [STAGES];
    logic [DW-1:0]     max_r;
    logic [CNT_W-1:0]  cnt_r;
    status_t           sticky_r;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mode2_sub_lane u_lane (
            .a      (`M2_LANE(in_data, i)),
            .b      (max_r),
            .z      (`M2_LANE(sub_data_s, i)),
            .status (lane_status_s[i])
        );
    end

    // Combine the per-lane exception flags of the beat at the input.
    always_comb begin
        beat_status_s = {STATUS_W{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            beat_status_s = beat_status_s | lane_status_s[i];
        end
    end

    // Advance chain: a stage moves when empty or when its successor moves.
    always_comb begin
        logic chain;
        adv_s = {STAGES{1'b0}};
        chain = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain    = !vld_r[k] || chain;
            adv_s[k] = chain;
        end
    end

    assign in_ready = adv_s[0];
    assign accept_s = in_valid && adv_s[0];

    // Elastic register chain; stalled stages hold data, last and valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_r  <= {STAGES{1'b0}};
            last_r <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                data_r[k] <= {LW{1'b0}};
            end
        end else begin
            if (adv_s[0]) begin
                vld_r[0] <= accept_s;
                if (accept_s) begin
                    data_r[0] <= sub_data_s;
                    last_r[0] <= in_last;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv_s[k]) begin
                    vld_r[k] <= vld_r[k-1];
                    if (vld_r[k-1]) begin
                        data_r[k] <= data_r[k-1];
                        last_r[k] <= last_r[k-1];
                    end
                end
            end
        end
    end

    // Max register, per-vector beat counter and sticky exception status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            max_r    <= {DW{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            sticky_r <= {STATUS_W{1'b0}};
        end else begin
            if (max_load) begin
                max_r <= max_in;
            end
            if (accept_s) begin
                if (in_last) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else if (cnt_r != CNT_MAX) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end
            // A coincident accept still lands in the freshly cleared status.
            if (max_load) begin
                sticky_r <= accept_s ? beat_status_s : {STATUS_W{1'b0}};
            end else if (accept_s) begin
                sticky_r <= sticky_r | beat_status_s;
            end
        end
    end

    assign out_valid     = vld_r[STAGES-1];
    assign out_data      = data_r[STAGES-1];
    assign out_last      = last_r[STAGES-1];
    assign busy          = |vld_r;
    assign beat_count    = cnt_r;
    assign status_sticky = sticky_r;

endmodule

// File: tb/tb_mode2_sub_pipe.sv
// Scoreboard bench for mode2_sub_pipe (fp16, 4 lanes, 2 stages).
module tb_mode2_sub_pipe;

    logic        clk, reset_n, max_load, in_valid, in_ready, in_last;
    logic        out_valid, out_ready, out_last, busy;
    logic [15:0] max_in;
    logic [63:0] in_data, out_data;
    logic [7:0]  beat_count, status_sticky;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [64:0] exp_q[$];
    logic [64:0] mon_exp;

    mode2_sub_pipe #(.NUM_LANES(4), .PIPE_STAGES(2), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .max_load(max_load), .max_in(max_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .beat_count(beat_count),
        .status_sticky(status_sticky), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] rep4(input logic [15:0] v);
        return {4{v}};
    endfunction

    // Monitor: pops on handshake, checks head-of-queue stability while stalled.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {63'd0, out_valid}, 64'd0);
            end else if (out_ready) begin
                mon_exp = exp_q.pop_front();
                check("out_data", out_data, mon_exp[64:1]);
                check("out_last", {63'd0, out_last}, {63'd0, mon_exp[0]});
            end else begin
                mon_exp = exp_q[0];
                check("stall_data", out_data, mon_exp[64:1]);
            end
        end
    end

    // Drive one beat (starting just after a posedge); push expectation on accept.
    task automatic send(input logic [63:0] d, input logic l, input logic [63:0] e,
                        input logic ml, input logic [15:0] mi);
        bit done;
        done     = 1'b0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        max_load = ml;
        max_in   = mi;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({e, l});
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        max_load = 1'b0;
    endtask

    task automatic load_max(input logic [15:0] v);
        max_load = 1'b1;
        max_in   = v;
        @(posedge clk);
        #1;
        max_load = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    logic [63:0] s_in [8];
    logic [63:0] s_exp[8];

    initial begin
        reset_n = 1'b0; max_load = 1'b0; max_in = 16'h0000; in_valid = 1'b0;
        in_data = 64'd0; in_last = 1'b0; out_ready = 1'b1;
        #3;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_beat_count", {56'd0, beat_count}, 64'd0);
        check("rst_status", {56'd0, status_sticky}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Single beat, latency exactly two cycles.
        load_max(16'h3C00);
        send(64'h4200_4000_3C00_0000, 1'b1, 64'h4000_3C00_0000_BC00, 1'b0, 16'h0000);
        check("single_count", {56'd0, beat_count}, 64'd0);
        @(negedge clk);
        check("lat_early", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("lat_on_time", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        check("lat_one_cycle", {63'd0, out_valid}, 64'd0);
        check("single_status", {56'd0, status_sticky}, 64'h01);
        @(posedge clk);
        #1;

        // Eight-beat stream, includes an RNE tie (4096 - 1 -> 4096, inexact).
        load_max(16'h3C00);
        check("load_clears_status", {56'd0, status_sticky}, 64'd0);
        s_in[0] = 64'h4000_4200_4400_4500; s_exp[0] = 64'h3C00_4000_4200_4400;
        s_in[1] = 64'h4600_4700_4800_3800; s_exp[1] = 64'h4500_4600_4700_B800;
        s_in[2] = 64'hBC00_4880_3E00_6C00; s_exp[2] = 64'hC000_4800_3800_6C00;
        for (int k = 3; k < 8; k++) begin
            for (int j = 0; j < 4; j++) begin
                s_in[k][j*16 +: 16]  = 16'h4880 + 16'((k - 3 + j) % 7) * 16'h0080;
                s_exp[k][j*16 +: 16] = 16'h4800 + 16'((k - 3 + j) % 7) * 16'h0080;
            end
        end
        for (int k = 0; k < 8; k++) begin
            send(s_in[k], k == 7, s_exp[k], 1'b0, 16'h0000);
            check("stream_count", {56'd0, beat_count}, (k == 7) ? 64'd0 : 64'(k + 1));
        end
        drain();
        check("stream_status", {56'd0, status_sticky}, 64'h20);

        // Beat counter saturation.
        for (int k = 0; k < 260; k++) send(rep4(16'h4000), 1'b0, rep4(16'h3C00), 1'b0, 16'h0000);
        check("count_saturate", {56'd0, beat_count}, 64'hFF);
        send(rep4(16'h4000), 1'b1, rep4(16'h3C00), 1'b0, 16'h0000);
        check("count_clear_last", {56'd0, beat_count}, 64'd0);
        drain();

        // Backpressure: out_ready low for five cycles.
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    send(rep4(16'h4880 + 16'(k) * 16'h0080), k == 5,
                         rep4(16'h4800 + 16'(k) * 16'h0080), 1'b0, 16'h0000);
                end
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
                check("bp_out_valid", {63'd0, out_valid}, 64'd1);
                check("bp_busy", {63'd0, busy}, 64'd1);
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // max_load coincident with an accept.
        load_max(16'h3C00);
        send(rep4(16'h4200), 1'b0, rep4(16'h4000), 1'b1, 16'h4000);
        send(rep4(16'h4200), 1'b1, rep4(16'h3C00), 1'b0, 16'h0000);
        drain();

        // inf - inf -> NaN with invalid, held until the next max_load.
        load_max(16'h7C00);
        check("exc_cleared", {56'd0, status_sticky}, 64'd0);
        send(rep4(16'h7C00), 1'b1, rep4(16'h7E00), 1'b0, 16'h0000);
        drain();
        check("exc_invalid_set", {63'd0, status_sticky[2]}, 64'd1);
        send(rep4(16'h4000), 1'b1, rep4(16'hFC00), 1'b0, 16'h0000);
        drain();
        check("exc_invalid_held", {63'd0, status_sticky[2]}, 64'd1);
        load_max(16'h3C00);
        check("exc_load_clears", {56'd0, status_sticky}, 64'd0);

        // Asynchronous reset with two beats in flight.
        send(rep4(16'h4000), 1'b0, rep4(16'h3C00), 1'b0, 16'h0000);
        send(rep4(16'h4200), 1'b0, rep4(16'h4000), 1'b0, 16'h0000);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_count", {56'd0, beat_count}, 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        exp_q.delete();
        in_valid = 1'b1;
        in_data  = rep4(16'h4400);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset_n  = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("post_rst_quiet", 64'(seen), 64'd0);
        end
        @(posedge clk);
        #1;
        // max_reg was reset to 0, so the beat passes through unchanged.
        send(rep4(16'h4200), 1'b1, rep4(16'h4200), 1'b0, 16'h0000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
